// File: rtl/cnt_date_pkg.sv
// Shared constants for the calendar date counter: month encodings, field widths
// and the reset date.
package cnt_date_pkg;

  localparam int unsigned DAY_W   = 5;
  localparam int unsigned MONTH_W = 4;

  typedef enum logic [MONTH_W-1:0] {
    JAN = 4'd1,
    FEB = 4'd2,
    MAR = 4'd3,
    APR = 4'd4,
    MAY = 4'd5,
    JUN = 4'd6,
    JUL = 4'd7,
    AUG = 4'd8,
    SEP = 4'd9,
    OCT = 4'd10,
    NOV = 4'd11,
    DEC = 4'd12
  } month_e;

  localparam logic [DAY_W-1:0]   RST_DAY   = 5'd1;
  localparam logic [MONTH_W-1:0] RST_MONTH = JAN;
  localparam int unsigned        RST_YEAR  = 0;

endpackage

// File: rtl/cnt_date_mlen.sv
// Days-in-month lookup; returns 0 for an out-of-range month.
// Leap-year February is enabled by defining CNT_DATE_LEAP_EN.
module cnt_date_mlen
  import cnt_date_pkg::*;
#(
  parameter int unsigned YEAR_W = 7
) (
  input  logic [MONTH_W-1:0] month,
  input  logic [YEAR_W-1:0]  year,
  output logic [DAY_W-1:0]   days
);

  // Only year[1:0] matters, and only in the leap build.
  logic unused_year;
  assign unused_year = ^year;

  always_comb begin
    days = '0;
    case (month)
      JAN, MAR, MAY, JUL, AUG, OCT, DEC: days = DAY_W'(31);
      APR, JUN, SEP, NOV:                days = DAY_W'(30);
      FEB: begin
`ifdef CNT_DATE_LEAP_EN
        days = (year[1:0] == 2'b00) ? DAY_W'(29) : DAY_W'(28);
`else
        days = DAY_W'(28);
`endif
      end
      default: days = '0;
    endcase
  end

endmodule

// File: rtl/cnt_date.sv
// Calendar date counter advanced by rising edges of inc_d, with validated load.
// Define CNT_DATE_LEAP_EN for leap-year Februaries (year[1:0] == 0).
module cnt_date
  import cnt_date_pkg::*;
#(
  parameter int unsigned YEAR_W   = 7,
  parameter int unsigned YEAR_MAX = 99
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc_d,
  input  logic               set_en,
  input  logic [DAY_W-1:0]   set_day,
  input  logic [MONTH_W-1:0] set_month,
  input  logic [YEAR_W-1:0]  set_year,
  output logic [DAY_W-1:0]   day,
  output logic [MONTH_W-1:0] month,
  output logic [YEAR_W-1:0]  year,
  output logic               inc_y,
  output logic               set_err
);

  localparam logic [YEAR_W-1:0] YEAR_LAST = YEAR_W'(YEAR_MAX);

  logic               inc_d_q;
  logic               armed;
  logic               step;
  logic [DAY_W-1:0]   cur_len;
  logic [DAY_W-1:0]   set_len;
  logic               set_ok;
  logic [DAY_W-1:0]   day_nx;
  logic [MONTH_W-1:0] month_nx;
  logic [YEAR_W-1:0]  year_nx;
  logic               wrap_y;

  cnt_date_mlen #(.YEAR_W(YEAR_W)) u_mlen_cur (
    .month (month),
    .year  (year),
    .days  (cur_len)
  );

  cnt_date_mlen #(.YEAR_W(YEAR_W)) u_mlen_set (
    .month (set_month),
    .year  (set_year),
    .days  (set_len)
  );

  // armed blocks a level that was already high across reset from counting;
  // it only differs from 1 until inc_d has been sampled low once.
  assign step = inc_d & ~inc_d_q & armed;

  // A zero length means the month itself is out of range.
  assign set_ok = (set_len != '0) && (set_year <= YEAR_LAST) &&
                  (set_day != '0) && (set_day <= set_len);

  always_comb begin
    day_nx   = day + DAY_W'(1);
    month_nx = month;
    year_nx  = year;
    wrap_y   = 1'b0;
    if (day >= cur_len) begin
      day_nx = RST_DAY;
      if (month >= DEC) begin
        month_nx = JAN;
        wrap_y   = 1'b1;
        year_nx  = (year >= YEAR_LAST) ? '0 : year + YEAR_W'(1);
      end else begin
        month_nx = month + MONTH_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      day     <= RST_DAY;
      month   <= RST_MONTH;
      year    <= YEAR_W'(RST_YEAR);
      inc_y   <= 1'b0;
      set_err <= 1'b0;
      inc_d_q <= 1'b0;
      armed   <= 1'b0;
    end else begin
      inc_d_q <= inc_d;
      inc_y   <= 1'b0;
      set_err <= 1'b0;
      if (!inc_d) begin
        armed <= 1'b1;
      end
      if (set_en) begin
        if (set_ok) begin
          day   <= set_day;
          month <= set_month;
          year  <= set_year;
        end else begin
          set_err <= 1'b1;
        end
      end else if (step) begin
        day   <= day_nx;
        month <= month_nx;
        year  <= year_nx;
        inc_y <= wrap_y;
      end
    end
  end

endmodule

// File: tb/tb_cnt_date.sv
// Self-checking bench for cnt_date: directed table, corner sequences and
// randomized stimulus against a calendar reference model.
module tb_cnt_date;

`ifdef CNT_DATE_LEAP_EN
  localparam bit LEAP = 1'b1;
`else
  localparam bit LEAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       inc_d;
  logic       set_en;
  logic [4:0] set_day;
  logic [3:0] set_month;
  logic [6:0] set_year;
  logic [4:0] day;
  logic [3:0] month;
  logic [6:0] year;
  logic       inc_y;
  logic       set_err;

  always #5 clk = ~clk;

  cnt_date #(.YEAR_W(7), .YEAR_MAX(99)) dut (
    .clk       (clk),
    .rst       (rst),
    .inc_d     (inc_d),
    .set_en    (set_en),
    .set_day   (set_day),
    .set_month (set_month),
    .set_year  (set_year),
    .day       (day),
    .month     (month),
    .year      (year),
    .inc_y     (inc_y),
    .set_err   (set_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_d, m_m, m_y;
  bit m_q, m_arm, m_incy, m_err;

  typedef struct {
    int ld_d;
    int ld_m;
    int ld_y;
    int pulses;
    int ed;
    int em;
    int ey;
    bit eerr;
  } vec_t;

  vec_t tbl[$];

  function automatic int dim(int m, int y);
    int lens[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m < 1 || m > 12) return 0;
    if (m == 2 && LEAP && (y % 4) == 0) return 29;
    return lens[m-1];
  endfunction

  function automatic bit valid_date(int d, int m, int y);
    return (m >= 1) && (m <= 12) && (y <= 99) && (d >= 1) && (d <= dim(m, y));
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_d = 1; m_m = 1; m_y = 0;
    m_q = 0; m_arm = 0; m_incy = 0; m_err = 0;
  endtask

  // One clock edge: predict from current inputs, then compare all outputs.
  task automatic cycle();
    int nd, nm, ny;
    bit nincy, nerr;
    nd = m_d; nm = m_m; ny = m_y; nincy = 0; nerr = 0;
    if (set_en) begin
      if (valid_date(set_day, set_month, set_year)) begin
        nd = set_day; nm = set_month; ny = set_year;
      end else begin
        nerr = 1;
      end
    end else if (inc_d && !m_q && m_arm) begin
      nd = m_d + 1;
      if (nd > dim(m_m, m_y)) begin
        nd = 1;
        nm = m_m + 1;
        if (nm > 12) begin
          nm = 1;
          ny = (m_y + 1) % 100;
          nincy = 1;
        end
      end
    end
    @(posedge clk);
    m_d = nd; m_m = nm; m_y = ny; m_incy = nincy; m_err = nerr;
    m_q = inc_d;
    if (!inc_d) m_arm = 1;
    #1;
    chk("day", day, m_d);
    chk("month", month, m_m);
    chk("year", year, m_y);
    chk("inc_y", inc_y, m_incy);
    chk("set_err", set_err, m_err);
  endtask

  task automatic load(input int d, input int m, input int y);
    set_en = 1'b1;
    set_day = 5'(d); set_month = 4'(m); set_year = 7'(y);
    cycle();
    set_en = 1'b0;
  endtask

  task automatic pulse();
    inc_d = 1'b1;
    cycle();
    inc_d = 1'b0;
    cycle();
  endtask

  task automatic chk_date(input string nm, input int d, input int m, input int y);
    chk({nm, "_day"}, day, d);
    chk({nm, "_month"}, month, m);
    chk({nm, "_year"}, year, y);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; inc_d = 1'b0; set_en = 1'b0;
    set_day = '0; set_month = '0; set_year = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_date("rst", 1, 1, 0);
    chk("rst_inc_y", inc_y, 0);
    chk("rst_set_err", set_err, 0);
    rst = 1'b0;
    cycle();

    // 31 days of January land on Feb 1
    repeat (31) pulse();
    chk_date("p31", 1, 2, 0);

    tbl.push_back('{28, 2, 1, 1, 1, 3, 1, 0});
    if (LEAP) tbl.push_back('{28, 2, 4, 1, 29, 2, 4, 0});
    else      tbl.push_back('{28, 2, 4, 1, 1, 3, 4, 0});
    tbl.push_back('{31, 12, 99, 1, 1, 1, 0, 0});
    tbl.push_back('{30, 4, 5, 0, 30, 4, 5, 0});
    tbl.push_back('{31, 4, 5, 0, 30, 4, 5, 1});
    tbl.push_back('{29, 2, 5, 0, 30, 4, 5, 1});
    tbl.push_back('{1, 13, 5, 0, 30, 4, 5, 1});
    tbl.push_back('{0, 3, 5, 0, 30, 4, 5, 1});
    tbl.push_back('{1, 1, 100, 0, 30, 4, 5, 1});
    tbl.push_back('{31, 1, 99, 1, 1, 2, 99, 0});
    tbl.push_back('{30, 11, 50, 1, 1, 12, 50, 0});
    if (LEAP) tbl.push_back('{29, 2, 8, 1, 1, 3, 8, 0});
    else      tbl.push_back('{29, 2, 8, 1, 2, 12, 50, 1});
    tbl.push_back('{31, 12, 3, 1, 1, 1, 4, 0});
    if (LEAP) tbl.push_back('{28, 2, 0, 2, 1, 3, 0, 0});
    else      tbl.push_back('{28, 2, 0, 2, 2, 3, 0, 0});

    foreach (tbl[i]) begin
      load(tbl[i].ld_d, tbl[i].ld_m, tbl[i].ld_y);
      chk("tbl_set_err", set_err, tbl[i].eerr);
      for (int p = 0; p < tbl[i].pulses; p++) pulse();
      chk_date("tbl", tbl[i].ed, tbl[i].em, tbl[i].ey);
    end

    // Year wrap: inc_y high for exactly one cycle
    load(31, 12, 99);
    inc_d = 1'b1;
    cycle();
    chk("wrap_inc_y_hi", inc_y, 1);
    chk_date("wrap", 1, 1, 0);
    inc_d = 1'b0;
    cycle();
    chk("wrap_inc_y_lo", inc_y, 0);

    // inc_d held high for 10 cycles counts once
    load(10, 3, 20);
    inc_d = 1'b1;
    repeat (10) cycle();
    inc_d = 1'b0;
    cycle();
    chk_date("hold", 11, 3, 20);

    // Load on the same edge as a rising inc_d: load wins, edge consumed
    set_en = 1'b1; set_day = 5'd15; set_month = 4'd6; set_year = 7'd7;
    inc_d = 1'b1;
    cycle();
    set_en = 1'b0;
    repeat (3) cycle();
    chk_date("simul", 15, 6, 7);
    inc_d = 1'b0;
    cycle();

    // Asynchronous reset between edges, inc_d high across it
    load(20, 8, 30);
    inc_d = 1'b1;
    cycle();
    chk_date("pre_arst", 21, 8, 30);
    #2;
    rst = 1'b1;
    #1;
    chk_date("arst", 1, 1, 0);
    chk("arst_inc_y", inc_y, 0);
    chk("arst_set_err", set_err, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) cycle();
    chk_date("arst_high", 1, 1, 0);
    inc_d = 1'b0;
    cycle();
    inc_d = 1'b1;
    cycle();
    chk_date("arst_rearm", 2, 1, 0);
    inc_d = 1'b0;
    cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 15);
      set_en = (r == 0);
      if (set_en) begin
        case ($urandom_range(0, 2))
          0: begin
            set_day = 5'($urandom_range(0, 31));
            set_month = 4'($urandom_range(0, 15));
            set_year = 7'($urandom_range(0, 127));
          end
          1: begin
            set_day = 5'd31; set_month = 4'd12;
            set_year = 7'($urandom_range(90, 99));
          end
          default: begin
            set_day = 5'($urandom_range(27, 29)); set_month = 4'd2;
            set_year = 7'($urandom_range(0, 99));
          end
        endcase
      end
      inc_d = ($urandom_range(0, 2) != 0) ? ~inc_d : inc_d;
      cycle();
    end
    set_en = 1'b0;
    inc_d = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
